rc4_s_mem_sequencer: RTL and testbench
======================================

// Module: rc4_s_mem_sequencer
// PURPOSE
//  Top-level phase controller for the RC4 core: owns the single-port S memory (256x8) and sequences
//  the three phases that use it: S-init (S[i]=i), key-schedule swap, PRGA/decrypt.
//  Starts each phase engine in turn. Routes only the active phase's memory port to the RAM.
//  Watchdogs each phase and reports done/error to the top-level FSM.
// PARAMETERS
//  ADDR_W       8     S-memory address width
//  DATA_W       8     S-memory data width
//  TIMEOUT_CYC  4096  max cycles a phase may run before error; must be >=2
// PORTS
//  clk           in   1         system clock
//  reset         in   1         synchronous, active-high reset
//  start         in   1         begin full sequence; sampled in IDLE/DONE only
//  ph_start      out  3         one-hot start pulse; [0]=init, [1]=ksa, [2]=prga
//  ph_done       in   3         per-phase finish pulse, same bit order
//  ph_req        in   3         per-phase memory access request
//  ph_addr       in   3*ADDR_W  per-phase address; phase p at [p*ADDR_W +: ADDR_W]
//  ph_wdata      in   3*DATA_W  per-phase write data, same packing
//  ph_wren       in   3         per-phase write enable
//  ph_gnt        out  3         per-phase grant, combinational
//  mem_addr      out  ADDR_W    to S RAM
//  mem_wdata     out  DATA_W    to S RAM
//  mem_wren      out  1         to S RAM
//  phase         out  2         0=none, 1=init, 2=ksa, 3=prga
//  busy          out  1         high in any RUN state
//  done          out  1         high in DONE
//  error         out  1         high in ERR
// BEHAVIOUR
//  States: IDLE, RUN_INIT, RUN_KSA, RUN_PRGA, DONE, ERR. All state is registered.
//  Reset values: state IDLE; ph_start 0; phase 0; busy/done/error 0; mem_addr 0; mem_wdata 0;
//   mem_wren 0; timeout counter 0.
//  Reset mid-run: state returns to IDLE on the next edge. No further write is issued after that edge.
//  IDLE/DONE + start=1 -> RUN_INIT at the next edge. start in a RUN state or in ERR is ignored.
//  ph_start[p] is high for exactly the first cycle spent in RUN_p. It is never high in any other state.
//  ph_done[active]=1 during a cycle -> next RUN state at the next edge:
//   INIT->KSA, KSA->PRGA, PRGA->DONE.
//  Next phase's ph_start and grant are valid from its first cycle, so there are zero idle cycles between phases.
//  ph_done of an inactive phase is ignored.
//  Grant: ph_gnt[p] = ph_req[p] & (state==RUN_p). Inactive requests are never granted. No queueing.
//  Memory mux is combinational from the active phase:
//   mem_addr/mem_wdata = ph_addr/ph_wdata of that phase.
//   mem_wren = ph_wren & ph_req & ph_gnt of that phase.
//  Outside RUN states: mem_wren=0, mem_addr=0, mem_wdata=0.
//  RAM read data goes straight to the phase engines and does not pass through this block.
//  Watchdog: counter is cleared on entry to every RUN state and increments each cycle in that state.
//  If the counter equals TIMEOUT_CYC-1 and ph_done[active]=0 -> ERR at the next edge.
//  If done and timeout occur in the same cycle, done wins.
//  ERR is sticky: error=1 until reset. busy=0 in ERR.
//  done is a level signal: it stays high in DONE until start is accepted again.
//  The last PRGA write before ph_done is forwarded normally: a write in the same cycle as ph_done is still issued.
// CONFIGURATION
//  Macro RC4_SEQ_CYCLE_CNT_EN.
//  Defined: adds output run_cycles [31:0] (reset 0).
//   Cleared on start acceptance; increments every RUN cycle; saturates at 32'hFFFF_FFFF.
//   Frozen in DONE/ERR.
//  Undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
//  - Reset, then start=1 for 1 cycle -> ph_start=3'b001 for exactly 1 cycle; phase=1; busy=1.
//  - In INIT, drive req/wren/addr=8'h05/wdata=8'h05 on port 0 -> mem_addr=8'h05, mem_wren=1.
//    Same cycle, req on port 2 -> ph_gnt[2]=0.
//  - ph_done=3'b001 -> next cycle ph_start=3'b010, phase=2.
//    Then ph_done=3'b100 while in KSA (wrong phase) -> no transition.
//  - Complete all 3 phases -> done=1, busy=0, mem_wren=0.
//    start again -> done=0, ph_start=3'b001.
//  - TIMEOUT_CYC=16, never assert done -> error=1 exactly 16 cycles after INIT entry.
//    error stays 1 while start pulses; clears only on reset.
//  - Assert reset mid-KSA while port 1 writes -> next cycle state IDLE, mem_wren=0, all outputs at reset values.
//    With RC4_SEQ_CYCLE_CNT_EN defined and phases of 256/768/300 cycles -> run_cycles=1324.

Source files
------------

// File: rtl/rc4_s_mem_sequencer.sv
// rc4_s_mem_sequencer
//   Phase controller for the RC4 core. Owns the single-port 256x8 S memory
//   and runs its three users in order: S-init, key-schedule swap, PRGA.
//   Only the active phase reaches the RAM, and a watchdog bounds each phase.
//   Optional feature macro: RC4_SEQ_CYCLE_CNT_EN adds the run_cycles counter.
module rc4_s_mem_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [2:0]          ph_start,
  input  logic [2:0]          ph_done,
  input  logic [2:0]          ph_req,
  input  logic [3*ADDR_W-1:0] ph_addr,
  input  logic [3*DATA_W-1:0] ph_wdata,
  input  logic [2:0]          ph_wren,
  output logic [2:0]          ph_gnt,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wren,
  output logic [1:0]          phase,
  output logic                busy,
  output logic                done,
`ifdef RC4_SEQ_CYCLE_CNT_EN
  output logic [31:0]         run_cycles,
`endif
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_INIT,
    S_RUN_KSA,
    S_RUN_PRGA,
    S_DONE,
    S_ERR
  } state_t;

  // The watchdog only needs to reach TIMEOUT_CYC-1.
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic [2:0]       run_mask;
  logic             run_done;
  logic             wd_expired;

  // One-hot mask of the phase that currently owns the memory.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    run_mask = 3'b000;
    case (state)
      S_RUN_INIT: run_mask = 3'b001;
      S_RUN_KSA:  run_mask = 3'b010;
      S_RUN_PRGA: run_mask = 3'b100;
      default:    run_mask = 3'b000;
    endcase
  end

  // Done pulses from inactive phases are masked off here.
  assign run_done   = |(ph_done & run_mask);
  assign wd_expired = (wd_cnt == CNT_LAST);
  assign ph_gnt     = ph_req & run_mask;

  // Memory port mux: forward the active phase only, zeros otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      S_RUN_INIT: begin
        mem_addr  = ph_addr[0*ADDR_W +: ADDR_W];
        mem_wdata = ph_wdata[0*DATA_W +: DATA_W];
        mem_wren  = ph_wren[0] & ph_req[0] & ph_gnt[0];
      end
      S_RUN_KSA: begin
        mem_addr  = ph_addr[1*ADDR_W +: ADDR_W];
        mem_wdata = ph_wdata[1*DATA_W +: DATA_W];
        mem_wren  = ph_wren[1] & ph_req[1] & ph_gnt[1];
      end
      S_RUN_PRGA: begin
        mem_addr  = ph_addr[2*ADDR_W +: ADDR_W];
        mem_wdata = ph_wdata[2*DATA_W +: DATA_W];
        mem_wren  = ph_wren[2] & ph_req[2] & ph_gnt[2];
      end
      default: ;
    endcase
  end

  // Phase FSM with registered status outputs and per-phase watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      state    <= S_IDLE;
      ph_start <= 3'b000;
      phase    <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      ph_start <= 3'b000;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_RUN_INIT;
            ph_start <= 3'b001;
            phase    <= 2'd1;
            busy     <= 1'b1;
            done     <= 1'b0;
            wd_cnt   <= '0;
          end
        end
        S_RUN_INIT, S_RUN_KSA, S_RUN_PRGA: begin
          // Done beats a simultaneous watchdog expiry.
          if (run_done) begin
            wd_cnt <= '0;
            case (state)
              S_RUN_INIT: begin
                state    <= S_RUN_KSA;
                ph_start <= 3'b010;
                phase    <= 2'd2;
              end
              S_RUN_KSA: begin
                state    <= S_RUN_PRGA;
                ph_start <= 3'b100;
                phase    <= 2'd3;
              end
              default: begin
                state <= S_DONE;
                phase <= 2'd0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            endcase
          end else if (wd_expired) begin
            state <= S_ERR;
            phase <= 2'd0;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RC4_SEQ_CYCLE_CNT_EN
  // Saturating count of RUN cycles for the current sequence; frozen outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      run_cycles <= '0;
    end else if (|run_mask && run_cycles != 32'hFFFF_FFFF) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rc4_s_mem_sequencer.sv
// tb_rc4_s_mem_sequencer
//   Randomised traffic against a phase-progress reference model.
//   Build with +define+RC4_SEQ_CYCLE_CNT_EN to also cover run_cycles.
module tb_rc4_s_mem_sequencer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int T  = 16;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [2:0]      ph_start, ph_done, ph_req, ph_wren, ph_gnt;
  logic [3*AW-1:0] ph_addr;
  logic [3*DW-1:0] ph_wdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_wren;
  logic [1:0]      phase;
  logic            busy, done, error;
`ifdef RC4_SEQ_CYCLE_CNT_EN
  logic [31:0]     run_cycles;
`endif

  always #5 clk = ~clk;

  rc4_s_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ph_start(ph_start), .ph_done(ph_done), .ph_req(ph_req),
    .ph_addr(ph_addr), .ph_wdata(ph_wdata), .ph_wren(ph_wren),
    .ph_gnt(ph_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .phase(phase), .busy(busy), .done(done),
`ifdef RC4_SEQ_CYCLE_CNT_EN
    .run_cycles(run_cycles),
`endif
    .error(error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which phase runs (0 = none), how long it has run,
  // whether this is its first cycle, and the sticky done/error flags.
  int          m_ph, m_age;
  bit          m_first, m_done, m_err;
  logic [31:0] m_rc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] amask;
    amask = (m_ph != 0) ? (3'b001 << (m_ph - 1)) : 3'b000;
    check("ph_start", ph_start, m_first ? amask : 3'b000);
    check("phase", phase, m_ph);
    check("busy", busy, m_ph != 0);
    check("done", done, m_done);
    check("error", error, m_err);
    check("ph_gnt", ph_gnt, ph_req & amask);
    if (m_ph != 0) begin
      check("mem_addr", mem_addr, ph_addr[(m_ph-1)*AW +: AW]);
      check("mem_wdata", mem_wdata, ph_wdata[(m_ph-1)*DW +: DW]);
      check("mem_wren", mem_wren, ph_wren[m_ph-1] & ph_req[m_ph-1]);
    end else begin
      check("mem_addr_idle", mem_addr, 0);
      check("mem_wdata_idle", mem_wdata, 0);
      check("mem_wren_idle", mem_wren, 0);
    end
`ifdef RC4_SEQ_CYCLE_CNT_EN
    check("run_cycles", run_cycles, m_rc);
`endif
  endtask

  // Advance the model across one clock edge using the inputs held at that edge.
  task automatic model_update();
    if (reset) begin
      m_ph = 0; m_age = 0; m_first = 0; m_done = 0; m_err = 0; m_rc = 0;
    end else if (m_err) begin
      m_first = 0;
    end else if (m_ph == 0) begin
      m_first = 0;
      if (start) begin
        m_ph = 1; m_age = 0; m_first = 1; m_done = 0; m_rc = 0;
      end
    end else begin
      if (m_rc != 32'hFFFF_FFFF) m_rc++;
      if (ph_done[m_ph-1]) begin
        if (m_ph == 3) begin
          m_ph = 0; m_first = 0; m_done = 1;
        end else begin
          m_ph++; m_age = 0; m_first = 1;
        end
      end else if (m_age == T - 1) begin
        m_ph = 0; m_first = 0; m_err = 1;
      end else begin
        m_age++; m_first = 0;
      end
    end
  endtask

  // Inputs are driven 1 ns after a rising edge; outputs are checked 1 ns later.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_traffic();
    ph_req   = 3'($urandom);
    ph_wren  = 3'($urandom);
    ph_addr  = 24'($urandom);
    ph_wdata = 24'($urandom);
  endtask

  // One full sequence with the given phase lengths (1..T cycles each).
  task automatic run_seq(input int d0, input int d1, input int d2);
    int         dur[3];
    logic [2:0] amask;
    dur[0] = d0; dur[1] = d1; dur[2] = d2;
    start = 1'b1; ph_done = 3'b000; rand_traffic();
    cyc();
    for (int k = 0; k < 100 && m_ph != 0; k++) begin
      rand_traffic();
      start   = 1'($urandom);
      amask   = 3'b001 << (m_ph - 1);
      ph_done = 3'($urandom) & ~amask;
      if (m_age == dur[m_ph-1] - 1) ph_done = ph_done | amask;
      cyc();
    end
    start = 1'b0; ph_done = 3'b000;
    check("seq_end_done", done, 1'b1);
    cyc();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ph_done = 3'b000;
    ph_req = 3'b000; ph_wren = 3'b000; ph_addr = '0; ph_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    m_ph = 0; m_age = 0; m_first = 0; m_done = 0; m_err = 0; m_rc = 0;
    cyc();
    reset = 1'b0;
    cyc();

    // Directed: start pulse, INIT write, cross-phase request not granted.
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("init_ph_start", ph_start, 3'b001);
    check("init_phase", phase, 2'd1);
    check("init_busy", busy, 1'b1);
    ph_req = 3'b101; ph_wren = 3'b001;
    ph_addr = {8'h33, 8'h22, 8'h05}; ph_wdata = {8'h66, 8'h44, 8'h05};
    #1;
    check("init_mem_addr", mem_addr, 8'h05);
    check("init_mem_wren", mem_wren, 1'b1);
    check("init_gnt2", ph_gnt[2], 1'b0);
    cyc();
    ph_done = 3'b001;
    cyc();
    ph_done = 3'b000;
    check("ksa_ph_start", ph_start, 3'b010);
    check("ksa_phase", phase, 2'd2);
    ph_done = 3'b100;
    repeat (3) cyc();
    check("ksa_ignore_prga_done", phase, 2'd2);
    ph_done = 3'b010;
    cyc();
    ph_done = 3'b100;
    ph_req = 3'b111; ph_wren = 3'b111;
    #1 check("prga_last_write", mem_wren, 1'b1);
    cyc();
    ph_done = 3'b000;
    #1;
    check("fin_done", done, 1'b1);
    check("fin_busy", busy, 1'b0);
    check("fin_mem_wren", mem_wren, 1'b0);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_done", done, 1'b0);
    check("restart_ph_start", ph_start, 3'b001);

    // Watchdog: no done ever; error appears exactly T cycles after INIT entry.
    ph_req = 3'b000; ph_wren = 3'b000;
    repeat (T - 1) cyc();
    check("wd_not_yet", error, 1'b0);
    cyc();
    check("wd_error", error, 1'b1);
    check("wd_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      start = k[0];
      cyc();
    end
    start = 1'b0;
    check("wd_sticky", error, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("wd_cleared", error, 1'b0);
    cyc();

    // Randomised sequences, then done arriving on the watchdog's last cycle.
    for (int s = 0; s < 6; s++)
      run_seq($urandom_range(1, T), $urandom_range(1, T), $urandom_range(1, T));
    run_seq(T, T, T);
    check("boundary_no_error", error, 1'b0);

`ifdef RC4_SEQ_CYCLE_CNT_EN
    run_seq(5, 12, 7);
    check("run_cycles_total", run_cycles, 32'd24);
    repeat (3) cyc();
    check("run_cycles_frozen", run_cycles, 32'd24);
`endif

    // Reset in the middle of KSA while port 1 is writing.
    start = 1'b1;
    cyc();
    start = 1'b0; ph_done = 3'b001;
    cyc();
    ph_done = 3'b000;
    ph_req = 3'b010; ph_wren = 3'b010;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rst_mid_wren", mem_wren, 1'b0);
    check("rst_mid_phase", phase, 2'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ph_start", ph_start, 3'b000);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
